// File: rtl/ste_dmm_pkg.sv
// Shared types and constants for the multimeter display datapath.
// Holds the converter FSM encoding, the BCD digit type and the default scale factors.
package ste_dmm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } fsm_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned DEFAULT_SCALE_MUL   = 1000;
  localparam int unsigned DEFAULT_SCALE_SHIFT = 16;

  // Largest value representable with the given number of decimal digits.
  function automatic int unsigned max_dec(input int unsigned digits);
    int unsigned v;
    v = 1;
    for (int unsigned i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

endpackage

// File: rtl/ste_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
// the concatenated {scratch, bin} register left by one bit.
module ste_dabble_step
  import ste_dmm_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] scratch,
  input  logic [4*DIGITS-1:0] bin,
  output logic [4*DIGITS-1:0] scratch_next,
  output logic [4*DIGITS-1:0] bin_next
);

  logic [4*DIGITS-1:0] adj;

  always_comb begin
    bcd_digit_t d;
    // NOTE: every always_comb output gets a full default before any
    // conditional update, so no latch can be inferred.
    d   = '0;
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      d = scratch[4*i +: 4];
      if (d >= 4'd5) adj[4*i +: 4] = d + 4'd3;
    end
    {scratch_next, bin_next} = {adj, bin} << 1;
  end

endmodule

// File: rtl/ste_bcd_conv.sv
// Scales an RMS ADC code to millivolts and converts it to packed BCD with a
// sequential double-dabble, one result per 4*DIGITS+2 cycles, one-deep pending slot.
module ste_bcd_conv
  import ste_dmm_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          MUL_W       = 16,
  parameter int unsigned SCALE_MUL   = DEFAULT_SCALE_MUL,
  parameter int unsigned SCALE_SHIFT = DEFAULT_SCALE_SHIFT,
  parameter int          DIGITS      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   din_i,
  input  logic                din_update_i,
  input  logic                clr_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                bcd_update_o,
  output logic                ovf_o,
  output logic                busy_o
);

  localparam int BIN_W  = 4 * DIGITS;
  localparam int PROD_W = DATA_W + MUL_W;
  localparam int CNT_W  = $clog2(BIN_W);

  localparam logic [PROD_W-1:0] MAX_DEC_P = PROD_W'(max_dec(DIGITS));
  localparam logic [BIN_W-1:0]  MAX_DEC_B = BIN_W'(max_dec(DIGITS));
  localparam logic [PROD_W-1:0] MUL_EXT   = PROD_W'(MUL_W'(SCALE_MUL));

  fsm_state_t        state;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] pend_data;
  logic              pend_valid;
  logic [BIN_W-1:0]  scratch;
  logic [BIN_W-1:0]  bin;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_next;

  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] val;
  logic              sat;
  logic [BIN_W-1:0]  val_sat;
  logic [BIN_W-1:0]  scratch_next;
  logic [BIN_W-1:0]  bin_next;

  // Truncating fixed-point scale, saturated to the largest displayable value.
  assign prod    = PROD_W'(operand) * MUL_EXT;
  assign val     = prod >> SCALE_SHIFT;
  assign sat     = (val > MAX_DEC_P);
  assign val_sat = sat ? MAX_DEC_B : BIN_W'(val);

  ste_dabble_step #(
    .DIGITS(DIGITS)
  ) u_step (
    .scratch     (scratch),
    .bin         (bin),
    .scratch_next(scratch_next),
    .bin_next    (bin_next)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      operand      <= '0;
      pend_data    <= '0;
      pend_valid   <= 1'b0;
      scratch      <= '0;
      bin          <= '0;
      cnt          <= '0;
      ovf_next     <= 1'b0;
      bcd_o        <= '0;
      bcd_update_o <= 1'b0;
      ovf_o        <= 1'b0;
      busy_o       <= 1'b0;
    end else if (clr_i) begin
      state        <= IDLE;
      pend_valid   <= 1'b0;
      bcd_o        <= '0;
      bcd_update_o <= 1'b0;
      ovf_o        <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      bcd_update_o <= 1'b0;
      if (din_update_i && (state == SCALE || state == SHIFT)) begin
        pend_data  <= din_i;
        pend_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (din_update_i || pend_valid) begin
            operand    <= din_update_i ? din_i : pend_data;
            pend_valid <= 1'b0;
            busy_o     <= 1'b1;
            state      <= SCALE;
          end
        end
        SCALE: begin
          scratch  <= '0;
          bin      <= val_sat;
          ovf_next <= sat;
          cnt      <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          scratch <= scratch_next;
          bin     <= bin_next;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) state <= DONE;
        end
        DONE: begin
          bcd_o        <= scratch;
          ovf_o        <= ovf_next;
          bcd_update_o <= 1'b1;
          // A strobe landing in DONE is newer than anything pending.
          if (din_update_i || pend_valid) begin
            operand    <= din_update_i ? din_i : pend_data;
            pend_valid <= 1'b0;
            state      <= SCALE;
          end else begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ste_bcd_conv.sv
// Scoreboard bench for ste_bcd_conv: a default-scale instance (a) and a
// SCALE_MUL=20000 instance (b) for saturation, each with its own queue and monitor.
module tb_ste_bcd_conv;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din_a, din_b;
  logic        upd_a, upd_b, clr_a, clr_b;
  logic [15:0] bcd_a, bcd_b;
  logic        bupd_a, bupd_b, ovf_a, ovf_b, busy_a, busy_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ste_bcd_conv dut_a (
    .clk(clk), .rst(rst), .din_i(din_a), .din_update_i(upd_a), .clr_i(clr_a),
    .bcd_o(bcd_a), .bcd_update_o(bupd_a), .ovf_o(ovf_a), .busy_o(busy_a)
  );

  ste_bcd_conv #(.SCALE_MUL(20000)) dut_b (
    .clk(clk), .rst(rst), .din_i(din_b), .din_update_i(upd_b), .clr_i(clr_b),
    .bcd_o(bcd_b), .bcd_update_o(bupd_b), .ovf_o(ovf_b), .busy_o(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every output strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bupd_a === 1'b1) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe_a: got bcd=%h ovf=%b, expected no strobe", bcd_a, ovf_a);
      end else begin
        e = q_a.pop_front();
        check("bcd_a", {16'h0, bcd_a}, {16'h0, e.bcd});
        check("ovf_a", {31'h0, ovf_a}, {31'h0, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bupd_b === 1'b1) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe_b: got bcd=%h ovf=%b, expected no strobe", bcd_b, ovf_b);
      end else begin
        e = q_b.pop_front();
        check("bcd_b", {16'h0, bcd_b}, {16'h0, e.bcd});
        check("ovf_b", {31'h0, ovf_b}, {31'h0, e.ovf});
      end
    end
  end

  task automatic strobe(input logic [15:0] d, input bit sel_b);
    if (sel_b) begin din_b = d; upd_b = 1'b1; end
    else       begin din_a = d; upd_a = 1'b1; end
    @(posedge clk); #1;
    upd_a = 1'b0;
    upd_b = 1'b0;
  endtask

  task automatic expect_res(input logic [15:0] bcd, input logic ovf, input bit sel_b);
    exp_t e;
    e.bcd = bcd;
    e.ovf = ovf;
    if (sel_b) q_b.push_back(e);
    else       q_a.push_back(e);
  endtask

  task automatic wait_drain(input bit sel_b);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (sel_b) begin
        if (q_b.size() == 0 && !busy_b) return;
      end else begin
        if (q_a.size() == 0 && !busy_a) return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL drain_timeout_%s: got pending results, expected drained queue", sel_b ? "b" : "a");
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    din_a = '0; din_b = '0;
    upd_a = 1'b0; upd_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("rst_bcd",  {16'h0, bcd_a},  32'h0);
    check("rst_upd",  {31'h0, bupd_a}, 32'h0);
    check("rst_ovf",  {31'h0, ovf_a},  32'h0);
    check("rst_busy", {31'h0, busy_a}, 32'h0);

    // Full-scale input and latency from strobe edge to update strobe.
    expect_res(16'h0999, 1'b0, 1'b0);
    strobe(16'hFFFF, 1'b0);
    check("busy_after_strobe", {31'h0, busy_a}, 32'h1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bupd_a) begin lat = i; break; end
    end
    check("latency", lat, 18);
    wait_drain(1'b0);
    idle(5);
    check("bcd_hold", {16'h0, bcd_a}, 32'h0999);

    // Directed single conversions.
    expect_res(16'h0062, 1'b0, 1'b0); strobe(16'h1015, 1'b0); wait_drain(1'b0);
    expect_res(16'h0312, 1'b0, 1'b0); strobe(16'h5015, 1'b0); wait_drain(1'b0);
    expect_res(16'h0500, 1'b0, 1'b0); strobe(16'h8000, 1'b0); wait_drain(1'b0);
    expect_res(16'h0000, 1'b0, 1'b0); strobe(16'h0000, 1'b0); wait_drain(1'b0);

    // Back-to-back: 0x5015 is overwritten in the pending slot by 0x006F.
    expect_res(16'h0062, 1'b0, 1'b0);
    expect_res(16'h0001, 1'b0, 1'b0);
    strobe(16'h1015, 1'b0);
    idle(1);
    strobe(16'h5015, 1'b0);
    idle(3);
    strobe(16'h006F, 1'b0);
    wait_drain(1'b0);
    idle(20);

    // Clear mid-shift with a simultaneous strobe: nothing may survive.
    strobe(16'h1015, 1'b0);
    idle(8);
    clr_a = 1'b1; upd_a = 1'b1; din_a = 16'h1234;
    @(posedge clk); #1;
    clr_a = 1'b0; upd_a = 1'b0;
    check("clr_bcd",  {16'h0, bcd_a},  32'h0);
    check("clr_busy", {31'h0, busy_a}, 32'h0);
    check("clr_ovf",  {31'h0, ovf_a},  32'h0);
    idle(40);
    check("clr_pending_empty", {31'h0, busy_a}, 32'h0);
    expect_res(16'h0062, 1'b0, 1'b0); strobe(16'h1015, 1'b0); wait_drain(1'b0);

    // Reset during shift with a pending value loaded.
    strobe(16'h5015, 1'b0);
    idle(3);
    strobe(16'h8000, 1'b0);
    idle(4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst2_bcd",  {16'h0, bcd_a},  32'h0);
    check("rst2_ovf",  {31'h0, ovf_a},  32'h0);
    check("rst2_busy", {31'h0, busy_a}, 32'h0);
    check("rst2_upd",  {31'h0, bupd_a}, 32'h0);
    idle(40);
    check("rst2_no_restart", {31'h0, busy_a}, 32'h0);
    check("rst2_bcd_hold",   {16'h0, bcd_a},  32'h0);

    // Saturation on the SCALE_MUL=20000 instance.
    expect_res(16'h9999, 1'b1, 1'b1); strobe(16'hFFFF, 1'b1); wait_drain(1'b1);
    expect_res(16'h0078, 1'b0, 1'b1); strobe(16'h0100, 1'b1); wait_drain(1'b1);
    expect_res(16'h9999, 1'b1, 1'b1); strobe(16'hFFFF, 1'b1); wait_drain(1'b1);
    clr_b = 1'b1;
    @(posedge clk); #1;
    clr_b = 1'b0;
    check("clr_b_bcd", {16'h0, bcd_b}, 32'h0);
    check("clr_b_ovf", {31'h0, ovf_b}, 32'h0);

    idle(5);
    check("queue_a_empty", q_a.size(), 0);
    check("queue_b_empty", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ste_bcd_conv.md
Name: ste_bcd_conv

Overview:
Downstream stage of the RMS block in the multimeter datapath. Consumes each RMS result word and its update strobe. Scales the raw ADC-code RMS value to millivolts by fixed-point multiply/shift, then runs a sequential double-dabble conversion into packed BCD digits. The digits feed the 7-segment display driver.

Parameters:
DATA_W, 16, width of incoming RMS word
MUL_W, 16, width of the scale multiplier constant
SCALE_MUL, 1000, multiplier giving mV full-scale (unsigned)
SCALE_SHIFT, 16, right shift applied after the multiply
DIGITS, 4, number of BCD output digits (BIN_W = 4*DIGITS)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
din_i  in  DATA_W  RMS value (unsigned ADC code)
din_update_i  in  1  one-cycle strobe: din_i valid
clr_i  in  1  synchronous clear (abort, drop pending, zero outputs)
bcd_o  out  4*DIGITS  packed BCD, digit 0 (LSD) in bits [3:0]
bcd_update_o  out  1  one-cycle strobe: bcd_o/ovf_o just updated
ovf_o  out  1  scaled value exceeded 10^DIGITS-1 (saturated)
busy_o  out  1  conversion in progress

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: bcd_o=0, bcd_update_o=0, ovf_o=0, busy_o=0. FSM returns to IDLE. Pending slot empties.
- Reset or clr asserted mid-conversion aborts the conversion with no output strobe.
- FSM states: IDLE, SCALE, SHIFT, DONE.
- IDLE: on din_update_i=1 (or pending valid), latch the operand and go to SCALE. busy_o=1 from the next cycle.
- SCALE (1 cycle):
  - prod = din * SCALE_MUL, full DATA_W+MUL_W width, unsigned.
  - val = prod >> SCALE_SHIFT.
  - If val > 10^DIGITS-1, set val = 10^DIGITS-1 and ovf_next=1.
  - Load the BIN_W-bit shift register. Clear the BCD scratch and counter.
- SHIFT (exactly BIN_W cycles):
  - Each cycle, add 3 to every scratch digit >=5, then shift {scratch, bin} left by 1.
  - Counter runs 0..BIN_W-1. Go to DONE after the last shift.
- DONE (1 cycle):
  - Register bcd_o and ovf_o, pulse bcd_update_o=1.
  - If pending valid, go to SCALE with the pending operand. Otherwise go to IDLE; busy_o=0 in IDLE.
- Latency: strobe sampled at edge 0 from IDLE gives bcd_update_o high in the cycle following edge BIN_W+2 (18 for defaults).
- Throughput: one result per BIN_W+2 cycles.
- Pending slot (one deep):
  - din_update_i while busy stores din_i into pending. A later strobe overwrites it (newest wins).
  - An accepted pending value clears the slot.
  - Strobe in the same cycle as DONE goes to pending and is taken immediately.
- clr_i:
  - Highest priority after rst. Forces IDLE, zeroes bcd_o and ovf_o, empties pending, bcd_update_o=0.
  - A din_update_i in the same cycle as clr_i is dropped.
- bcd_o holds its value between strobes. Outputs never change outside DONE, clr or rst.
- Arithmetic: all unsigned, no rounding (truncation). din=0 yields bcd_o=0.

Decomposition:
- Package ste_dmm_pkg:
  - fsm state enum (IDLE/SCALE/SHIFT/DONE)
  - BCD digit typedef (logic [3:0])
  - function max_dec(DIGITS) returning 10^DIGITS-1
  - default SCALE_MUL/SCALE_SHIFT constants
- Sub-module ste_dabble_step: combinational add-3 per digit plus 1-bit shift for one iteration. Instantiated once; the FSM register holds the state.

Test Plan:
- Reset, then din=16'hFFFF strobed once -> after 18 cycles bcd_update_o pulses; bcd_o=16'h0999, ovf_o=0.
- Strobe 16'h1015 -> bcd_o=16'h0062. Strobe 16'h5015 -> 16'h0312. Strobe 16'h8000 -> 16'h0500. Strobe 0 -> 16'h0000.
- Back-to-back: 16'h1015, then 16'h5015 two cycles later, then 16'h006F four cycles later:
  - exactly two strobes, 16'h0062 then 16'h0001 (111*1000>>16=1);
  - 16'h5015 is overwritten in pending.
- Overflow: SCALE_MUL=20000, din=16'hFFFF -> bcd_o=16'h9999, ovf_o=1. A following din=16'h0100 (SCALE_MUL=20000, 5120000>>16=78) -> 16'h0078, ovf_o=0.
- clr_i mid-SHIFT (cycle 8 of conversion), with din_update_i high in the same cycle -> no strobe; bcd_o=0, busy_o=0 next cycle; pending empty. Afterwards 16'h1015 converts normally to 16'h0062.
- rst asserted for 1 cycle during SHIFT with pending loaded -> all outputs 0, no strobe ever emitted for the aborted or pending values.
